alu_sequencer: RTL and testbench

- Command-level sequencer and accumulator for the ALU. It owns the ACC register, takes one command per start pulse, and drives the ALU operands, `ctrl_alu_op`, `ctrl_alu_en` and the bus strobes C9/C10.
- It reads BR/MR back from the ALU result bus and captures the ALU flags.
- It sits between the control unit (command/handshake side) and the ALU (initiator side of the ALU enable/C9/C10 protocol).

---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_sequencer.sv | 99 +++++++++
 tb/tb_alu_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: commands, ALU op codes,
// FSM state codes and flag bit positions.
package alu_seq_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] CMD_NOP       = 4'd0;
    localparam logic [3:0] CMD_LOAD      = 4'd1;
    localparam logic [3:0] CMD_ALU_FIRST = 4'd2;
    localparam logic [3:0] CMD_ALU_LAST  = 4'd9;
    localparam logic [3:0] CMD_STOREH    = 4'd10;
    localparam logic [3:0] CMD_CLR       = 4'd11;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MPY = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_NOT = 3'd5,
        OP_SHR = 3'd6,
        OP_SHL = 3'd7
    } alu_op_e;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EXEC = 3'd1;
    localparam logic [2:0] ST_WB   = 3'd2;
    localparam logic [2:0] ST_WBH  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int FLAG_ZF = 4;
    localparam int FLAG_CF = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NF = 1;
    localparam int FLAG_MF = 0;

    function automatic logic is_alu_cmd(input logic [3:0] cmd);
        return (cmd >= CMD_ALU_FIRST) && (cmd <= CMD_ALU_LAST);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command sequencer and accumulator: issues one command per start pulse,
// drives the ALU enable/C9/C10 handshake and writes results back into ACC.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [3:0]        i_cmd,
    input  logic [DATA_W-1:0] i_operand,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_acc,
    output logic [DATA_W-1:0] o_alu_p,
    output logic [DATA_W-1:0] o_alu_q,
    output logic [2:0]        o_alu_op,
    output logic              o_alu_en,
    output logic              o_c9,
    output logic              o_c10,
    input  logic [DATA_W-1:0] i_alu_bus,
    input  logic [4:0]        i_alu_flags,
    output logic [4:0]        o_flags,
    output logic [DATA_W-1:0] o_mr_data
);

    logic [2:0]        state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] q_reg;
    logic [2:0]        alu_op_reg;
    logic [4:0]        flags_reg;
    logic [DATA_W-1:0] mr_reg;
    logic [3:0]        cmd_off;
    logic              accept;

    assign cmd_off = i_cmd - CMD_ALU_FIRST;
    assign accept  = i_start && ((state == ST_IDLE) || (state == ST_DONE));

    // Non-ALU commands latch op 0 so o_alu_op never shows a stale code.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            q_reg      <= '0;
            alu_op_reg <= '0;
            flags_reg  <= '0;
            mr_reg     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        q_reg      <= i_operand;
                        alu_op_reg <= is_alu_cmd(i_cmd) ? cmd_off[2:0] : 3'd0;
                        if (is_alu_cmd(i_cmd)) begin
                            state <= ST_EXEC;
                        end else if (i_cmd == CMD_STOREH) begin
                            state <= ST_WBH;
                        end else if (i_cmd == CMD_LOAD) begin
                            acc   <= i_operand;
                            state <= ST_DONE;
                        end else if (i_cmd == CMD_CLR) begin
                            acc   <= '0;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_EXEC: state <= ST_WB;
                ST_WB: begin
                    acc       <= i_alu_bus;
                    flags_reg <= i_alu_flags;
                    state     <= (alu_op_reg == OP_MPY) ? ST_WBH : ST_DONE;
                end
                ST_WBH: begin
                    mr_reg <= i_alu_bus;
                    state  <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_alu_en  = (state == ST_EXEC);
    assign o_c9      = (state == ST_WB);
    assign o_c10     = (state == ST_WBH);
    assign o_busy    = o_alu_en || o_c9 || o_c10;
    assign o_done    = (state == ST_DONE);
    assign o_acc     = acc;
    assign o_alu_p   = acc;
    assign o_alu_q   = q_reg;
    assign o_alu_op  = (state == ST_IDLE) ? 3'd0 : alu_op_reg;
    assign o_flags   = flags_reg;
    assign o_mr_data = mr_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU on the bus side.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [3:0]  i_cmd;
    logic [15:0] i_operand;
    logic        o_busy, o_done, o_alu_en, o_c9, o_c10;
    logic [15:0] o_acc, o_alu_p, o_alu_q, o_mr_data, i_alu_bus;
    logic [2:0]  o_alu_op;
    logic [4:0]  i_alu_flags, o_flags;

    int checks = 0;
    int failures = 0;

    alu_sequencer #(.DATA_W(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_cmd(i_cmd),
        .i_operand(i_operand), .o_busy(o_busy), .o_done(o_done), .o_acc(o_acc),
        .o_alu_p(o_alu_p), .o_alu_q(o_alu_q), .o_alu_op(o_alu_op),
        .o_alu_en(o_alu_en), .o_c9(o_c9), .o_c10(o_c10), .i_alu_bus(i_alu_bus),
        .i_alu_flags(i_alu_flags), .o_flags(o_flags), .o_mr_data(o_mr_data)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural ALU: latches BR/MR/flags on an enabled edge, drives the bus on C9/C10.
    logic [15:0] alu_br = '0;
    logic [15:0] alu_mr = '0;
    logic [4:0]  alu_fl = '0;
    always @(posedge i_clk) begin
        if (o_alu_en) begin
            logic [16:0] sum;
            logic [31:0] prod;
            logic [15:0] r;
            logic        cf, ovf, mf;
            cf = 1'b0; ovf = 1'b0; mf = 1'b0; r = '0;
            case (o_alu_op)
                OP_ADD: begin
                    sum = {1'b0, o_alu_p} + {1'b0, o_alu_q};
                    r = sum[15:0]; cf = sum[16];
                    ovf = (o_alu_p[15] == o_alu_q[15]) && (r[15] != o_alu_p[15]);
                end
                OP_SUB: begin
                    r = o_alu_p - o_alu_q; cf = (o_alu_p < o_alu_q);
                    ovf = (o_alu_p[15] != o_alu_q[15]) && (r[15] != o_alu_p[15]);
                end
                OP_MPY: begin
                    prod = o_alu_p * o_alu_q;
                    r = prod[15:0]; alu_mr <= prod[31:16]; mf = (prod[31:16] != 16'd0);
                end
                OP_AND: r = o_alu_p & o_alu_q;
                OP_OR:  r = o_alu_p | o_alu_q;
                OP_NOT: r = ~o_alu_p;
                OP_SHR: r = o_alu_p >> 1;
                default: r = o_alu_p << 1;
            endcase
            alu_br <= r;
            alu_fl <= {(r == 16'd0), cf, ovf, r[15], mf};
        end
    end
    assign i_alu_bus   = o_c9 ? alu_br : (o_c10 ? alu_mr : 16'd0);
    assign i_alu_flags = alu_fl;

    typedef struct {
        logic [3:0]  cmd;
        logic [15:0] operand;
        int          exp_done;
        logic [15:0] exp_acc;
        logic [4:0]  exp_flags;
        logic [15:0] exp_mr;
    } vec_t;

    vec_t vecs[18];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one command from the current negedge and follows it to o_done.
    task automatic applyStimulus(input vec_t v, input int idx);
        int en_cyc = 0, c9_cyc = 0, c10_cyc = 0, done_cyc = 0;
        int x_en, x_c9, x_c10;
        logic excl_ok = 1'b1;
        logic busy1 = 1'b0;
        logic [2:0] op_at_done = '0;
        logic is_alu;
        is_alu = (v.cmd >= 4'd2) && (v.cmd <= 4'd9);
        i_start = 1'b1; i_cmd = v.cmd; i_operand = v.operand;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc == 1) busy1 = o_busy;
            if (o_alu_en) en_cyc = cyc;
            if (o_c9) c9_cyc = cyc;
            if (o_c10) c10_cyc = cyc;
            if ((int'(o_alu_en) + int'(o_c9) + int'(o_c10)) > 1) excl_ok = 1'b0;
            if (o_done) begin
                if (o_alu_en || o_c9 || o_c10 || o_busy) excl_ok = 1'b0;
                done_cyc = cyc;
                op_at_done = o_alu_op;
                break;
            end
            @(negedge i_clk);
        end
        x_en  = is_alu ? 1 : 0;
        x_c9  = is_alu ? 2 : 0;
        x_c10 = (v.cmd == 4'd4) ? 3 : ((v.cmd == 4'd10) ? 1 : 0);
        checkOutput($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
        checkOutput($sformatf("v%0d_acc", idx), o_acc, v.exp_acc);
        checkOutput($sformatf("v%0d_alu_p", idx), o_alu_p, v.exp_acc);
        checkOutput($sformatf("v%0d_flags", idx), o_flags, v.exp_flags);
        checkOutput($sformatf("v%0d_mr", idx), o_mr_data, v.exp_mr);
        checkOutput($sformatf("v%0d_alu_q", idx), o_alu_q, v.operand);
        checkOutput($sformatf("v%0d_alu_op", idx), op_at_done, is_alu ? (v.cmd - 4'd2) : 0);
        checkOutput($sformatf("v%0d_strobe_cycles", idx), {en_cyc[7:0], c9_cyc[7:0], c10_cyc[7:0]},
                    {x_en[7:0], x_c9[7:0], x_c10[7:0]});
        checkOutput($sformatf("v%0d_busy_c1", idx), busy1, v.exp_done != 1);
        checkOutput($sformatf("v%0d_exclusive", idx), excl_ok, 1'b1);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name, {o_acc, o_alu_p}, 32'd0);
        checkOutput({name, "_q_mr"}, {o_alu_q, o_mr_data}, 32'd0);
        checkOutput({name, "_ctl"}, {o_alu_op, o_alu_en, o_c9, o_c10, o_busy, o_done, o_flags}, 32'd0);
    endtask

    initial begin
        // cmd, operand, done cycle, acc, flags {ZF,CF,OF,NF,MF}, MR
        vecs[0]  = '{4'd1,  16'h0005, 1, 16'h0005, 5'b00000, 16'h0000};
        vecs[1]  = '{4'd2,  16'h0003, 3, 16'h0008, 5'b00000, 16'h0000};
        vecs[2]  = '{4'd1,  16'h0005, 1, 16'h0005, 5'b00000, 16'h0000};
        vecs[3]  = '{4'd3,  16'h0005, 3, 16'h0000, 5'b10000, 16'h0000};
        vecs[4]  = '{4'd1,  16'h7FFF, 1, 16'h7FFF, 5'b10000, 16'h0000};
        vecs[5]  = '{4'd2,  16'h0001, 3, 16'h8000, 5'b00110, 16'h0000};
        vecs[6]  = '{4'd1,  16'h0100, 1, 16'h0100, 5'b00110, 16'h0000};
        vecs[7]  = '{4'd4,  16'h0100, 4, 16'h0000, 5'b10001, 16'h0001};
        vecs[8]  = '{4'd10, 16'h0000, 2, 16'h0000, 5'b10001, 16'h0001};
        vecs[9]  = '{4'd1,  16'h00F0, 1, 16'h00F0, 5'b10001, 16'h0001};
        vecs[10] = '{4'd5,  16'h0F3C, 3, 16'h0030, 5'b00000, 16'h0001};
        vecs[11] = '{4'd6,  16'h0F00, 3, 16'h0F30, 5'b00000, 16'h0001};
        vecs[12] = '{4'd7,  16'h0000, 3, 16'hF0CF, 5'b00010, 16'h0001};
        vecs[13] = '{4'd8,  16'h0000, 3, 16'h7867, 5'b00000, 16'h0001};
        vecs[14] = '{4'd9,  16'h0000, 3, 16'hF0CE, 5'b00010, 16'h0001};
        vecs[15] = '{4'd13, 16'h1111, 1, 16'hF0CE, 5'b00010, 16'h0001};
        vecs[16] = '{4'd11, 16'h2222, 1, 16'h0000, 5'b00010, 16'h0001};
        vecs[17] = '{4'd0,  16'h3333, 1, 16'h0000, 5'b00010, 16'h0001};

        i_rst_n = 1'b0; i_start = 1'b0; i_cmd = '0; i_operand = '0;
        #3;
        checkAllZero("reset_state");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Each vector is issued in the DONE cycle of the previous one.
        foreach (vecs[i]) applyStimulus(vecs[i], i);
        @(negedge i_clk);
        checkOutput("idle_after_done", {o_busy, o_done}, 2'b00);

        // Start during WB must be ignored.
        applyStimulus('{4'd1, 16'h0010, 1, 16'h0010, 5'b00010, 16'h0001}, 100);
        i_start = 1'b1; i_cmd = 4'd2; i_operand = 16'h0001;
        @(posedge i_clk); @(negedge i_clk);
        i_start = 1'b0;
        checkOutput("busy_exec", o_alu_en, 1'b1);
        @(negedge i_clk);
        checkOutput("busy_wb", o_c9, 1'b1);
        i_start = 1'b1; i_cmd = 4'd2; i_operand = 16'h0100;
        @(posedge i_clk); @(negedge i_clk);
        i_start = 1'b0;
        checkOutput("ignored_done", o_done, 1'b1);
        checkOutput("ignored_acc", o_acc, 16'h0011);
        checkOutput("ignored_q", o_alu_q, 16'h0001);
        @(negedge i_clk);
        checkOutput("ignored_idle", {o_busy, o_done, o_alu_en, o_alu_op}, 6'd0);
        checkOutput("ignored_acc2", o_acc, 16'h0011);

        // Async reset during WB of an AND.
        applyStimulus('{4'd1, 16'hFFFF, 1, 16'hFFFF, 5'b00000, 16'h0001}, 101);
        i_start = 1'b1; i_cmd = 4'd5; i_operand = 16'h00FF;
        @(posedge i_clk); @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        checkOutput("and_wb", {o_c9, o_alu_op}, {1'b1, 3'd3});
        #2 i_rst_n = 1'b0;
        #1 checkAllZero("async_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checkAllZero("after_release");
        applyStimulus('{4'd1, 16'h1234, 1, 16'h1234, 5'b00000, 16'h0000}, 102);
        @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
